bus_master_if: RTL and testbench

- CPU-side initiator for the byte-wide memory bus.
- Accepts single-byte read, two-byte burst read (opcode + immediate, e.g. lbi) and single-byte write requests from the core.
- Sequences eab/mdout/cword to the RAM and captures edb.
- Sits between the core control FSM and the RAM; it is the only driver of the memory address, data-out and control-word lines.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_master_if.sv | 129 ++++++++++++
 tb/tb_bus_master_if.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the byte-wide memory bus initiator.
// Control-word and state encodings plus default bus widths.
package bus_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef logic [1:0] cword_t;

  localparam cword_t CW_IDLE  = 2'b00;
  localparam cword_t CW_WRITE = 2'b01;
  localparam cword_t CW_READ  = 2'b10;
  localparam cword_t CW_RSVD  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RD0   = 3'd1;
  localparam state_t S_RD1   = 3'd2;
  localparam state_t S_WR    = 3'd3;
  localparam state_t S_WDONE = 3'd4;

endpackage

// File: rtl/bus_master_if.sv
// CPU-side bus initiator: sequences eab/mdout/cword to the RAM
// and captures edb for single, two-byte burst reads and writes.
module bus_master_if
  import bus_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk2,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic          burst2,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          rlast,
  output logic          wdone,
  output logic [AW-1:0] eab,
  output logic [DW-1:0] mdout,
  output logic [1:0]    cword,
  input  logic [DW-1:0] edb
);

  state_t        state_q, state_d;
  logic [AW-1:0] eab_q, eab_d;
  logic [DW-1:0] mdout_q, mdout_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          burst_q, burst_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic          wdone_q, wdone_d;
  cword_t        cword_q, cword_d;

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      eab_q    <= '0;
      mdout_q  <= '0;
      rdata_q  <= '0;
      burst_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      wdone_q  <= 1'b0;
      cword_q  <= CW_IDLE;
    end else begin
      state_q  <= state_d;
      eab_q    <= eab_d;
      mdout_q  <= mdout_d;
      rdata_q  <= rdata_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
      wdone_q  <= wdone_d;
      cword_q  <= cword_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    eab_d    = eab_q;
    mdout_d  = mdout_q;
    rdata_d  = rdata_q;
    burst_d  = burst_q;
    rvalid_d = 1'b0;
    rlast_d  = 1'b0;
    wdone_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          eab_d   = addr;
          burst_d = burst2 & ~we;
          if (we) begin
            mdout_d = wdata;
            state_d = S_WR;
          end else begin
            state_d = S_RD0;
          end
        end
      end
      S_RD0: begin
        rdata_d  = edb;
        rvalid_d = 1'b1;
        if (burst_q) begin
          eab_d   = eab_q + AW'(1);
          state_d = S_RD1;
        end else begin
          rlast_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_RD1: begin
        rdata_d  = edb;
        rvalid_d = 1'b1;
        rlast_d  = 1'b1;
        state_d  = S_IDLE;
      end
      S_WR: begin
        wdone_d = 1'b1;
        state_d = S_WDONE;
      end
      S_WDONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // cword is decoded from the next state so the flop lines up with state_q
  always_comb begin
    cword_d = CW_IDLE;
    unique case (1'b1)
      (state_d == S_RD0),
      (state_d == S_RD1): cword_d = CW_READ;
      (state_d == S_WR):  cword_d = CW_WRITE;
      default:            cword_d = CW_IDLE;
    endcase
  end

  assign ready  = (state_q == S_IDLE);
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rlast  = rlast_q;
  assign wdone  = wdone_q;
  assign eab    = eab_q;
  assign mdout  = mdout_q;
  assign cword  = cword_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if with a behavioural byte RAM.
// Expected bytes, addresses and writes are queued at issue time.
module tb_bus_master_if;

  logic       clk2 = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic       burst2 = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       ready, rvalid, rlast, wdone;
  logic [7:0] rdata, eab, mdout, edb;
  logic [1:0] cword;

  bus_master_if #(.AW(8), .DW(8)) dut (
    .clk2(clk2), .reset(reset), .req(req), .we(we),
    .burst2(burst2), .addr(addr), .wdata(wdata),
    .ready(ready), .rvalid(rvalid), .rdata(rdata),
    .rlast(rlast), .wdone(wdone), .eab(eab),
    .mdout(mdout), .cword(cword), .edb(edb)
  );

  always #5 clk2 = ~clk2;

  logic [7:0] ram [256];
  logic [7:0] model [256];
  logic       ram_init = 1'b0;

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'((i * 37 + 11) & 255);
    if (i == 5) v = 8'h0B;
    if (i == 0) v = 8'hC4;
    if (i == 1) v = 8'h06;
    return v;
  endfunction

  always @(posedge clk2) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (cword == 2'b01) begin
      ram[eab] <= mdout;
    end
  end

  assign edb = ram[eab];

  int errors = 0;
  int checks = 0;
  int wr_issued = 0;
  int wdone_cnt = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [8:0]  rd_q [$];
  logic [7:0]  ra_q [$];
  logic [15:0] wr_q [$];

  always @(negedge clk2) begin
    if (reset && ram_init) begin
      if (rvalid) begin
        check("rv_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) begin
          logic [8:0] e;
          e = rd_q.pop_front();
          check("rdata", 32'(rdata), 32'(e[7:0]));
          check("rlast", 32'(rlast), 32'(e[8]));
        end
      end
      if (cword == 2'b10) begin
        check("rd_expected", 32'(ra_q.size() != 0), 1);
        if (ra_q.size() != 0) check("rd_eab", 32'(eab), 32'(ra_q.pop_front()));
      end
      if (cword == 2'b01) begin
        check("wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          logic [15:0] w;
          w = wr_q.pop_front();
          check("wr_eab", 32'(eab), 32'(w[15:8]));
          check("wr_mdout", 32'(mdout), 32'(w[7:0]));
        end
      end
      check("cword_legal", 32'(cword != 2'b11), 1);
      if (wdone) wdone_cnt++;
    end
  end

  task automatic push_exp(input logic w, input logic b2,
                          input logic [7:0] a, input logic [7:0] d);
    logic [7:0] a1;
    a1 = a + 8'd1;
    if (w) begin
      model[a] = d;
      wr_q.push_back({a, d});
      wr_issued++;
    end else begin
      ra_q.push_back(a);
      rd_q.push_back({~b2, model[a]});
      if (b2) begin
        ra_q.push_back(a1);
        rd_q.push_back({1'b1, model[a1]});
      end
    end
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk2);
    while (!ready && n < 50) begin
      @(negedge clk2);
      n++;
    end
    check(tag, 32'(ready), 1);
  endtask

  task automatic do_req(input logic w, input logic b2,
                        input logic [7:0] a, input logic [7:0] d);
    wait_ready("ready_wait");
    req = 1'b1; we = w; burst2 = b2; addr = a; wdata = d;
    push_exp(w, b2, a, d);
    @(posedge clk2);
    #1 req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model[i] = init_val(i);
    repeat (2) @(posedge clk2);
    #1 ram_init = 1'b1;
    check("rst_ready", 32'(ready), 1);
    check("rst_cword", 32'(cword), 0);
    check("rst_eab", 32'(eab), 0);
    check("rst_mdout", 32'(mdout), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_wdone", 32'(wdone), 0);
    @(negedge clk2);
    reset = 1'b1;

    do_req(1'b0, 1'b0, 8'd5, 8'h00);
    do_req(1'b0, 1'b1, 8'd0, 8'h00);
    do_req(1'b0, 1'b1, 8'hFF, 8'h00);
    do_req(1'b1, 1'b0, 8'd9, 8'h2A);
    do_req(1'b0, 1'b0, 8'd9, 8'h00);

    // req held through an in-flight burst, then taken with rlast
    wait_ready("b2b_ready0");
    req = 1'b1; we = 1'b0; burst2 = 1'b1; addr = 8'd0;
    push_exp(1'b0, 1'b1, 8'd0, 8'h00);
    @(posedge clk2);
    #1 addr = 8'd5; burst2 = 1'b0;
    push_exp(1'b0, 1'b0, 8'd5, 8'h00);
    wait_ready("b2b_ready1");
    check("b2b_rlast", 32'(rlast), 1);
    @(posedge clk2);
    #1 req = 1'b0;

    for (int k = 0; k < 10; k++) begin
      logic       w, b2;
      logic [7:0] a, d;
      w  = 1'($urandom_range(0, 1));
      b2 = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(10, 255));
      d  = 8'($urandom);
      do_req(w, b2, a, d);
    end

    begin
      int n;
      n = 0;
      while ((rd_q.size() + wr_q.size() + ra_q.size()) != 0 && n < 50) begin
        @(negedge clk2);
        n++;
      end
      check("sb_drained", 32'(rd_q.size() + wr_q.size() + ra_q.size()), 0);
    end
    wait_ready("ready_final");
    check("wdone_count", 32'(wdone_cnt), 32'(wr_issued));
    check("mem9_written", 32'(ram[9]), 32'h2A);

    // reset dropped while the write strobe is on the bus
    wait_ready("mw_ready");
    req = 1'b1; we = 1'b1; burst2 = 1'b0; addr = 8'd9; wdata = 8'h55;
    @(posedge clk2);
    #1 req = 1'b0;
    check("mw_cword_wr", 32'(cword), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("mw_cword", 32'(cword), 0);
    check("mw_ready", 32'(ready), 1);
    check("mw_eab", 32'(eab), 0);
    check("mw_mdout", 32'(mdout), 0);
    check("mw_wdone", 32'(wdone), 0);
    check("mw_rvalid", 32'(rvalid), 0);
    repeat (2) @(posedge clk2);
    #1 check("mw_mem9", 32'(ram[9]), 32'h2A);
    @(negedge clk2);
    reset = 1'b1;
    @(negedge clk2);
    check("mw_ready_after", 32'(ready), 1);
    check("mw_no_wdone", 32'(wdone_cnt), 32'(wr_issued));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
